// File: rtl/fifo_drain_ctrl.sv
// FIFO-to-SPI drain controller: tracks FIFO occupancy and moves words to an
// SPI transmitter in threshold-triggered or flush-triggered bursts.
module fifo_drain_ctrl #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 32,
    parameter int THRESHOLD = 8,
    parameter int BURST_LEN = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_wr_en,
    input  logic             fifo_full,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_rd_en,
    input  logic             flush,
    input  logic             spi_ready,
    output logic             spi_valid,
    output logic [WIDTH-1:0] spi_data,
    output logic             busy,
    output logic [5:0]       level,
    output logic [15:0]      burst_cnt,
    output logic             overflow
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD   = 3'd1;
    localparam logic [2:0] CAP  = 3'd2;
    localparam logic [2:0] TX   = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    localparam logic [5:0]  THR     = 6'(THRESHOLD);
    localparam logic [5:0]  LVL_MAX = 6'(DEPTH);
    localparam logic [15:0] BLEN    = 16'(BURST_LEN);

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [5:0]  level_nxt;
    logic [15:0] word_cnt;
    logic        flush_pend;
    logic        flush_burst;
    logic        wr_ok;
    logic        start;
    logic        start_flush;
    logic        pend_clr;
    logic        more;

    // Guard against a producer that ignores the full flag.
    assign wr_ok      = fifo_wr_en && !fifo_full && (level != LVL_MAX);
    assign fifo_rd_en = (state == RD) && !fifo_empty;
    assign spi_valid  = (state == TX);
    assign busy       = (state != IDLE);

    assign start_flush = flush_pend && (level != 6'd0);
    assign start       = start_flush || (level >= THR);
    assign pend_clr    = (state == IDLE) && (start_flush || level == 6'd0);

    always_comb begin
        level_nxt = level;
        if (wr_ok && !fifo_rd_en) begin
            level_nxt = level + 6'd1;
        end else if (!wr_ok && fifo_rd_en) begin
            level_nxt = level - 6'd1;
        end
    end

    // A flush burst keeps going while anything is left, including late writes.
    always_comb begin
        more = 1'b0;
        if (flush_burst) begin
            more = (level_nxt != 6'd0);
        end else begin
            more = ((word_cnt + 16'd1) < BLEN) && (level_nxt != 6'd0);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RD;
            RD:   state_nxt = fifo_empty ? DONE : CAP;
            CAP:  state_nxt = TX;
            TX:   if (spi_ready) state_nxt = more ? RD : DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            level       <= '0;
            burst_cnt   <= '0;
            overflow    <= 1'b0;
            flush_pend  <= 1'b0;
            flush_burst <= 1'b0;
            word_cnt    <= '0;
            spi_data    <= '0;
        end else begin
            state      <= state_nxt;
            level      <= level_nxt;
            overflow   <= overflow | (fifo_wr_en & fifo_full);
            flush_pend <= flush | (flush_pend & ~pend_clr);
            if (state == IDLE && start) begin
                flush_burst <= start_flush;
                word_cnt    <= '0;
            end
            if (state == TX && spi_ready) begin
                word_cnt <= word_cnt + 16'd1;
            end
            if (state == CAP) begin
                spi_data <= fifo_dout;
            end
            if (state == DONE) begin
                burst_cnt <= burst_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: behavioural FIFO in front, scoreboard of
// written words checked against every SPI handshake.
module tb_fifo_drain_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_wr_en = 1'b0;
    logic        fifo_full;
    logic        fifo_empty;
    logic [15:0] fifo_dout;
    logic        fifo_rd_en;
    logic        flush = 1'b0;
    logic        spi_ready = 1'b0;
    logic        spi_valid;
    logic [15:0] spi_data;
    logic        busy;
    logic [5:0]  level;
    logic [15:0] burst_cnt;
    logic        overflow;

    logic [15:0] wr_data = '0;
    logic [15:0] mem [0:31];
    logic [4:0]  wptr;
    logic [4:0]  rptr;
    logic [5:0]  cnt;

    int n_vec = 0;
    int n_err = 0;
    int hs_cnt = 0;
    int cyc = 0;
    int rd_cyc = -1;
    int val_cyc = -1;
    logic [15:0] exp_q [$];

    fifo_drain_ctrl dut (
        .clk(clk), .rst(rst),
        .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd_en(fifo_rd_en), .flush(flush),
        .spi_ready(spi_ready), .spi_valid(spi_valid),
        .spi_data(spi_data), .busy(busy), .level(level),
        .burst_cnt(burst_cnt), .overflow(overflow)
    );

    always #5 clk = ~clk;

    assign fifo_full  = (cnt == 6'd32);
    assign fifo_empty = (cnt == 6'd0);

    // External 32-deep FIFO sharing the controller's reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            wptr      <= '0;
            rptr      <= '0;
            fifo_dout <= '0;
        end else begin
            if (fifo_wr_en && !fifo_full) begin
                mem[wptr] <= wr_data;
                wptr      <= wptr + 5'd1;
            end
            if (fifo_rd_en && !fifo_empty) begin
                fifo_dout <= mem[rptr];
                rptr      <= rptr + 5'd1;
            end
            cnt <= cnt + 6'(fifo_wr_en && !fifo_full)
                       - 6'(fifo_rd_en && !fifo_empty);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (fifo_rd_en && rd_cyc < 0) rd_cyc = cyc;
            if (spi_valid && val_cyc < 0) val_cyc = cyc;
            if (spi_valid && spi_ready) begin
                hs_cnt++;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL handshake: got %h, none expected", spi_data);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    if (spi_data !== e) begin
                        n_err++;
                        $display("FAIL handshake: got %h want %h", spi_data, e);
                    end
                end
            end
        end
    end

    task automatic push_words(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            fifo_wr_en = 1'b1;
            wr_data = base + 16'(i);
            if (!fifo_full) exp_q.push_back(wr_data);
        end
        @(negedge clk);
        fifo_wr_en = 1'b0;
    endtask

    task automatic wait_bc(input logic [15:0] target, input int budget,
                           input string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (burst_cnt == target) break;
        end
        n_vec++;
        if (burst_cnt !== target) begin
            n_err++;
            $display("FAIL %s burst_cnt: got %0d want %0d", name, burst_cnt, target);
        end
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (spi_valid) break;
        end
        n_vec++;
        if (spi_valid !== 1'b1) begin
            n_err++;
            $display("FAIL %s spi_valid: got %b want 1", name, spi_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_vec += 7;
        if (busy !== 1'b0) begin n_err++; $display("FAIL rst busy: got %b want 0", busy); end
        if (spi_valid !== 1'b0) begin n_err++; $display("FAIL rst spi_valid: got %b want 0", spi_valid); end
        if (fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL rst rd_en: got %b want 0", fifo_rd_en); end
        if (level !== 6'd0) begin n_err++; $display("FAIL rst level: got %0d want 0", level); end
        if (burst_cnt !== 16'd0) begin n_err++; $display("FAIL rst burst_cnt: got %0d want 0", burst_cnt); end
        if (overflow !== 1'b0) begin n_err++; $display("FAIL rst overflow: got %b want 0", overflow); end
        if (spi_data !== 16'd0) begin n_err++; $display("FAIL rst spi_data: got %h want 0", spi_data); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_threshold();
        int h0;
        h0 = hs_cnt;
        spi_ready = 1'b1;
        rd_cyc = -1;
        val_cyc = -1;
        push_words(8, 16'h0001);
        wait_bc(16'd1, 100, "threshold");
        n_vec += 4;
        if (hs_cnt - h0 != 8) begin n_err++; $display("FAIL threshold words: got %0d want 8", hs_cnt - h0); end
        if (rd_cyc < 0 || val_cyc - rd_cyc != 2) begin
            n_err++;
            $display("FAIL threshold latency: got %0d want 2", val_cyc - rd_cyc);
        end
        if (level !== 6'd0) begin n_err++; $display("FAIL threshold level: got %0d want 0", level); end
        if (exp_q.size() != 0) begin n_err++; $display("FAIL threshold leftover: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_partial();
        int h0;
        logic [15:0] bc0;
        h0 = hs_cnt;
        bc0 = burst_cnt;
        push_words(5, 16'h0101);
        repeat (10) @(negedge clk);
        #1;
        n_vec += 2;
        if (busy !== 1'b0) begin n_err++; $display("FAIL partial busy: got %b want 0", busy); end
        if (level !== 6'd5) begin n_err++; $display("FAIL partial level: got %0d want 5", level); end
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_bc(bc0 + 16'd1, 100, "partial");
        n_vec += 2;
        if (hs_cnt - h0 != 5) begin n_err++; $display("FAIL partial words: got %0d want 5", hs_cnt - h0); end
        if (level !== 6'd0) begin n_err++; $display("FAIL partial end level: got %0d want 0", level); end
    endtask

    task automatic test_backpressure();
        int h0;
        logic [15:0] bc0;
        logic [15:0] held;
        h0 = hs_cnt;
        bc0 = burst_cnt;
        spi_ready = 1'b0;
        push_words(8, 16'h0201);
        wait_valid("backpressure");
        held = spi_data;
        n_vec++;
        if (held !== 16'h0201) begin n_err++; $display("FAIL bp first word: got %h want 0201", held); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            n_vec++;
            if (spi_valid !== 1'b1 || spi_data !== held) begin
                n_err++;
                $display("FAIL bp hold %0d: got valid=%b data=%h want 1/%h", i, spi_valid, spi_data, held);
            end
        end
        @(negedge clk);
        spi_ready = 1'b1;
        wait_bc(bc0 + 16'd1, 100, "backpressure");
        n_vec += 2;
        if (hs_cnt - h0 != 8) begin n_err++; $display("FAIL bp words: got %0d want 8", hs_cnt - h0); end
        if (level !== 6'd0) begin n_err++; $display("FAIL bp level: got %0d want 0", level); end
    endtask

    task automatic test_concurrent();
        int h0;
        logic [15:0] bc0;
        logic [5:0] lv;
        bit found;
        h0 = hs_cnt;
        bc0 = burst_cnt;
        found = 1'b0;
        spi_ready = 1'b1;
        push_words(8, 16'h0301);
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (fifo_rd_en) begin
                lv = level;
                fifo_wr_en = 1'b1;
                wr_data = 16'h0309;
                if (!fifo_full) exp_q.push_back(wr_data);
                flush = 1'b1;
                @(negedge clk);
                fifo_wr_en = 1'b0;
                flush = 1'b0;
                #1;
                found = 1'b1;
                n_vec++;
                if (level !== lv) begin n_err++; $display("FAIL rd+wr level: got %0d want %0d", level, lv); end
            end
        end
        n_vec++;
        if (!found) begin n_err++; $display("FAIL rd+wr: got no read, want one"); end
        wait_bc(bc0 + 16'd1, 100, "normal burst");
        n_vec += 2;
        if (hs_cnt - h0 != 8) begin n_err++; $display("FAIL normal words: got %0d want 8", hs_cnt - h0); end
        if (level !== 6'd1) begin n_err++; $display("FAIL normal level: got %0d want 1", level); end
        @(negedge clk);
        #1;
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL flush follow busy: got %b want 1", busy); end
        wait_bc(bc0 + 16'd2, 50, "flush burst");
        n_vec += 2;
        if (hs_cnt - h0 != 9) begin n_err++; $display("FAIL flush words: got %0d want 9", hs_cnt - h0); end
        if (level !== 6'd0) begin n_err++; $display("FAIL flush level: got %0d want 0", level); end
    endtask

    // The burst triggered at 8 words pulls one word into TX before the FIFO
    // fills, so a 34th attempt is the one that meets a full FIFO.
    task automatic test_overflow();
        int h0;
        logic [15:0] bc0;
        bc0 = burst_cnt;
        spi_ready = 1'b0;
        push_words(34, 16'h0401);
        #1;
        n_vec += 2;
        if (level !== 6'd32) begin n_err++; $display("FAIL full level: got %0d want 32", level); end
        if (overflow !== 1'b1) begin n_err++; $display("FAIL overflow: got %b want 1", overflow); end
        h0 = hs_cnt;
        @(negedge clk);
        spi_ready = 1'b1;
        wait_bc(bc0 + 16'd1, 100, "full burst");
        n_vec += 2;
        if (hs_cnt - h0 != 8) begin n_err++; $display("FAIL full burst words: got %0d want 8", hs_cnt - h0); end
        if (level !== 6'd25) begin n_err++; $display("FAIL full burst level: got %0d want 25", level); end
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            #1;
            if (!busy && level == 6'd0) break;
        end
        n_vec += 2;
        if (busy !== 1'b0 || level !== 6'd0) begin
            n_err++;
            $display("FAIL drain: got busy=%b level=%0d want 0/0", busy, level);
        end
        if (exp_q.size() != 0) begin n_err++; $display("FAIL drain leftover: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        spi_ready = 1'b0;
        push_words(8, 16'h0501);
        wait_valid("reset mid");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        n_vec += 5;
        if (spi_valid !== 1'b0) begin n_err++; $display("FAIL mid rst spi_valid: got %b want 0", spi_valid); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL mid rst busy: got %b want 0", busy); end
        if (level !== 6'd0) begin n_err++; $display("FAIL mid rst level: got %0d want 0", level); end
        if (overflow !== 1'b0) begin n_err++; $display("FAIL mid rst overflow: got %b want 0", overflow); end
        if (burst_cnt !== 16'd0) begin n_err++; $display("FAIL mid rst burst_cnt: got %0d want 0", burst_cnt); end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        if (busy !== 1'b0 || level !== 6'd0) begin
            n_err++;
            $display("FAIL after rst: got busy=%b level=%0d want 0/0", busy, level);
        end
    endtask

    initial begin
        test_reset();
        test_threshold();
        test_partial();
        test_backpressure();
        test_concurrent();
        test_overflow();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
